// File: rtl/status_reg.sv
// -----------------------------------------------------------------------------
// status_reg : processor status (P) register
//
// Consumes ALU results and flags, executes flag set/clear operations, supplies
// the byte pushed for PHP/BRK and IRQ/NMI entry, and runs a PLP pull-status
// read handshake with a bounded wait on the stack memory port.
//
// P layout: [7]N [6]V [5]1 [4]B(1) [3]D [2]I [1]Z [0]C
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alu_Y, alu_flags    ALU result byte / flag byte (V = bit 6, C = bit 0)
//   alu_upd, alu_mask   capture enable and per-flag mask (bits 7,6,1,0)
//   flag_op_en, flag_op flag set/clear operation (CLC..CLV, 111 = no-op)
//   php_req, irq_entry  push-byte requests (PHP/BRK, IRQ/NMI)
//   plp_req             start pull-status read
//   mem_rd_ack/_data    read completion and pulled byte
//   mem_rd_req          read request, held while waiting
//   push_valid/_data    one-cycle push strobe and byte
//   plp_err             one-cycle timeout strobe
//   busy                PLP read in progress
//   p_reg               current P
//   alu_carry/alu_BCD/irq_mask  direct views of P bits 0/3/2
//
// Build option: define STATUS_CMOS_DCLR_EN to make interrupt entry also clear
// D (65C02 behaviour); otherwise D is left unchanged (NMOS behaviour).
// -----------------------------------------------------------------------------
module status_reg #(
  parameter logic [7:0] RESET_P     = 8'h34,
  parameter int         PLP_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_Y,
  input  logic [7:0] alu_flags,
  input  logic       alu_upd,
  input  logic [7:0] alu_mask,
  input  logic       flag_op_en,
  input  logic [2:0] flag_op,
  input  logic       php_req,
  input  logic       irq_entry,
  input  logic       plp_req,
  input  logic       mem_rd_ack,
  input  logic [7:0] mem_rd_data,
  output logic       mem_rd_req,
  output logic       push_valid,
  output logic [7:0] push_data,
  output logic       plp_err,
  output logic       busy,
  output logic [7:0] p_reg,
  output logic       alu_carry,
  output logic       alu_BCD,
  output logic       irq_mask
);

  // Last counter value before the read is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(PLP_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] p_next;
  logic       mem_rd_req_next;
  logic       busy_next;
  logic       push_valid_next;
  logic [7:0] push_data_next;
  logic       plp_err_next;

  // Input bits that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{alu_flags[7], alu_flags[5:1], alu_mask[5:2], mem_rd_data[5:4]};

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    p_next          = p_reg;
    mem_rd_req_next = 1'b0;
    busy_next       = 1'b0;
    push_valid_next = 1'b0;
    push_data_next  = push_data;
    plp_err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // ALU capture first so that a flag_op on the same bit overrides it.
        if (alu_upd) begin
          if (alu_mask[7]) p_next[7] = alu_Y[7];
          if (alu_mask[6]) p_next[6] = alu_flags[6];
          if (alu_mask[1]) p_next[1] = (alu_Y == 8'h00);
          if (alu_mask[0]) p_next[0] = alu_flags[0];
        end

        if (flag_op_en) begin
          case (flag_op)
            3'b000:  p_next[0] = 1'b0;  // CLC
            3'b001:  p_next[0] = 1'b1;  // SEC
            3'b010:  p_next[2] = 1'b0;  // CLI
            3'b011:  p_next[2] = 1'b1;  // SEI
            3'b100:  p_next[3] = 1'b0;  // CLD
            3'b101:  p_next[3] = 1'b1;  // SED
            3'b110:  p_next[6] = 1'b0;  // CLV
            default: ;                  // no-op
          endcase
        end

        // Push bytes are built from the pre-edge P; interrupt entry takes
        // priority over PHP and its I=1 overrides any CLI in the same cycle.
        if (irq_entry) begin
          push_valid_next = 1'b1;
          push_data_next  = (p_reg | 8'h20) & 8'hEF;
          p_next[2]       = 1'b1;
`ifdef STATUS_CMOS_DCLR_EN
          p_next[3]       = 1'b0;
`endif
        end else if (php_req) begin
          push_valid_next = 1'b1;
          push_data_next  = p_reg | 8'h30;
        end

        if (plp_req) begin
          state_next      = ST_WAIT;
          cnt_next        = 8'd0;
          mem_rd_req_next = 1'b1;
          busy_next       = 1'b1;
        end
      end

      ST_WAIT: begin
        // An ack on the expiry cycle still completes the load.
        if (mem_rd_ack) begin
          p_next     = {mem_rd_data[7:6], 2'b11, mem_rd_data[3:0]};
          state_next = ST_IDLE;
        end else if (cnt_reg == TMO_LAST) begin
          plp_err_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_next        = cnt_reg + 8'd1;
          mem_rd_req_next = 1'b1;
          busy_next       = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Bits 5 and 4 are hard-wired to 1.
    p_next[5:4] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 8'd0;
      p_reg      <= RESET_P | 8'h30;
      mem_rd_req <= 1'b0;
      busy       <= 1'b0;
      push_valid <= 1'b0;
      push_data  <= 8'h00;
      plp_err    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      p_reg      <= p_next;
      mem_rd_req <= mem_rd_req_next;
      busy       <= busy_next;
      push_valid <= push_valid_next;
      push_data  <= push_data_next;
      plp_err    <= plp_err_next;
    end
  end

  assign alu_carry = p_reg[0];
  assign alu_BCD   = p_reg[3];
  assign irq_mask  = p_reg[2];

endmodule

// File: tb/tb_status_reg.sv
// -----------------------------------------------------------------------------
// tb_status_reg : directed self-checking bench for status_reg
// -----------------------------------------------------------------------------
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_Y, alu_flags, alu_mask, mem_rd_data;
  logic       alu_upd, flag_op_en, php_req, irq_entry, plp_req, mem_rd_ack;
  logic [2:0] flag_op;
  logic       mem_rd_req, push_valid, plp_err, busy;
  logic [7:0] push_data, p_reg;
  logic       alu_carry, alu_BCD, irq_mask;

  int n_cmp = 0;
  int n_bad = 0;

  status_reg #(.RESET_P(8'h34), .PLP_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .alu_Y(alu_Y), .alu_flags(alu_flags), .alu_upd(alu_upd), .alu_mask(alu_mask),
    .flag_op_en(flag_op_en), .flag_op(flag_op),
    .php_req(php_req), .irq_entry(irq_entry), .plp_req(plp_req),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .mem_rd_req(mem_rd_req), .push_valid(push_valid), .push_data(push_data),
    .plp_err(plp_err), .busy(busy), .p_reg(p_reg),
    .alu_carry(alu_carry), .alu_BCD(alu_BCD), .irq_mask(irq_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_Y = 8'h00; alu_flags = 8'h00; alu_mask = 8'h00; alu_upd = 1'b0;
    flag_op_en = 1'b0; flag_op = 3'b111;
    php_req = 1'b0; irq_entry = 1'b0; plp_req = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
  endtask

  task automatic do_flag_op(input logic [2:0] op);
    flag_op_en = 1'b1; flag_op = op;
    tick();
    idle_inputs();
  endtask

  initial begin
    int first_err;
    int pulses;

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_p",          p_reg, 8'h34);
    chk("rst_mem_rd_req", {7'd0, mem_rd_req}, 8'h00);
    chk("rst_busy",       {7'd0, busy}, 8'h00);
    chk("rst_push_valid", {7'd0, push_valid}, 8'h00);
    chk("rst_push_data",  push_data, 8'h00);
    chk("rst_plp_err",    {7'd0, plp_err}, 8'h00);
    chk("rst_irq_mask",   {7'd0, irq_mask}, 8'h01);
    rst = 1'b0;

    // ALU capture of all four flags: N=0 Z=1 V=1 C=1.
    alu_upd = 1'b1; alu_mask = 8'hC3; alu_Y = 8'h00; alu_flags = 8'h41;
    tick();
    idle_inputs();
    chk("alu_cap_p",     p_reg, 8'h77);
    chk("alu_cap_carry", {7'd0, alu_carry}, 8'h01);

    do_flag_op(3'b000);                          // CLC
    chk("clc", p_reg, 8'h76);

    // SEC alongside ALU capture clearing C: flag_op wins.
    alu_upd = 1'b1; alu_mask = 8'h01; alu_flags = 8'h00;
    flag_op_en = 1'b1; flag_op = 3'b001;
    tick();
    idle_inputs();
    chk("sec_vs_alu", p_reg, 8'h77);

    do_flag_op(3'b110);                          // CLV
    chk("clv", p_reg, 8'h37);
    do_flag_op(3'b101);                          // SED
    chk("sed", p_reg, 8'h3F);
    chk("bcd", {7'd0, alu_BCD}, 8'h01);
    do_flag_op(3'b100);                          // CLD
    chk("cld", p_reg, 8'h37);
    do_flag_op(3'b010);                          // CLI
    chk("cli", p_reg, 8'h33);
    chk("cli_mask", {7'd0, irq_mask}, 8'h00);
    do_flag_op(3'b011);                          // SEI
    chk("sei", p_reg, 8'h37);

    // Clear N/Z/V/C via ALU with a nonzero result; N from bit 7 = 0.
    alu_upd = 1'b1; alu_mask = 8'hC3; alu_Y = 8'h01; alu_flags = 8'h00;
    tick();
    idle_inputs();
    chk("alu_clear", p_reg, 8'h34);

    // Interrupt entry: push byte has B=0.
    irq_entry = 1'b1;
    tick();
    idle_inputs();
    chk("irq_push_valid", {7'd0, push_valid}, 8'h01);
    chk("irq_push_data",  push_data, 8'h24);
    chk("irq_p",          p_reg, 8'h34);
    tick();
    chk("push_valid_drop", {7'd0, push_valid}, 8'h00);

    // CLI with interrupt entry: I=1 wins.
    irq_entry = 1'b1; flag_op_en = 1'b1; flag_op = 3'b010;
    tick();
    idle_inputs();
    chk("irq_cli_p", p_reg, 8'h34);

    php_req = 1'b1;
    tick();
    idle_inputs();
    chk("php_push_data", push_data, 8'h34);

    // PHP and IRQ together: interrupt byte is pushed.
    php_req = 1'b1; irq_entry = 1'b1;
    tick();
    idle_inputs();
    chk("php_irq_data", push_data, 8'h24);

    do_flag_op(3'b101);                          // SED -> 3C
    irq_entry = 1'b1;
    tick();
    idle_inputs();
    chk("irq_d_push", push_data, 8'h2C);
`ifdef STATUS_CMOS_DCLR_EN
    chk("irq_d_p", p_reg, 8'h34);
`else
    chk("irq_d_p", p_reg, 8'h3C);
`endif
    do_flag_op(3'b100);                          // CLD -> 34

    // PLP with ack on the third wait cycle; requests during WAIT ignored.
    plp_req = 1'b1;
    tick();
    idle_inputs();
    chk("plp_req_c1",  {7'd0, mem_rd_req}, 8'h01);
    chk("plp_busy_c1", {7'd0, busy}, 8'h01);
    alu_upd = 1'b1; alu_mask = 8'hFF; alu_Y = 8'h80; alu_flags = 8'h41; php_req = 1'b1;
    tick();
    chk("plp_req_c2",    {7'd0, mem_rd_req}, 8'h01);
    chk("wait_no_push",  {7'd0, push_valid}, 8'h00);
    chk("wait_no_alu",   p_reg, 8'h34);
    tick();
    chk("plp_req_c3", {7'd0, mem_rd_req}, 8'h01);
    idle_inputs();
    mem_rd_ack = 1'b1; mem_rd_data = 8'hC3;
    tick();
    idle_inputs();
    chk("plp_load_p",  p_reg, 8'hF3);
    chk("plp_req_low", {7'd0, mem_rd_req}, 8'h00);
    chk("plp_busy_low", {7'd0, busy}, 8'h00);

    // Ack while idle is ignored.
    mem_rd_ack = 1'b1; mem_rd_data = 8'h00;
    tick();
    idle_inputs();
    chk("idle_ack_p", p_reg, 8'hF3);

    // Timeout: exactly one plp_err, 15 cycles after mem_rd_req rises.
    plp_req = 1'b1;
    tick();
    idle_inputs();
    first_err = -1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (plp_err) begin
        pulses++;
        if (first_err < 0) first_err = i;
      end
    end
    chk("tmo_cycle",  8'(first_err), 8'd15);
    chk("tmo_pulses", 8'(pulses), 8'd1);
    chk("tmo_p",      p_reg, 8'hF3);
    chk("tmo_busy",   {7'd0, busy}, 8'h00);

    // Ack on the expiry cycle: load wins, no error.
    plp_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    chk("exp_still_req", {7'd0, mem_rd_req}, 8'h01);
    mem_rd_ack = 1'b1; mem_rd_data = 8'h01;
    tick();
    idle_inputs();
    chk("exp_ack_p",   p_reg, 8'h31);
    chk("exp_ack_err", {7'd0, plp_err}, 8'h00);
    tick();
    chk("exp_ack_err2", {7'd0, plp_err}, 8'h00);

    // Reset two cycles into WAIT aborts silently.
    plp_req = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_p",    p_reg, 8'h34);
    chk("midrst_req",  {7'd0, mem_rd_req}, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    chk("midrst_err",  {7'd0, plp_err}, 8'h00);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plp_err) pulses++;
    end
    chk("midrst_no_err", 8'(pulses), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
